// File: rtl/ddr3_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ddr3_port_arbiter_if
// Bundles the client-side request/return signals and the DDR3 controller
// Avalon-MM signals that pass through the arbiter.
//   slave  : arbiter view (client requests and controller responses in,
//            client handshakes and controller commands out)
//   master : environment view (clients plus controller)
// Client vectors are packed per port: port i at [i*W +: W].
// ---------------------------------------------------------------------------
interface ddr3_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 128,
  parameter int SIZE_WIDTH = 3
);
  logic [NUM_PORTS-1:0]            port_rd_req;
  logic [NUM_PORTS-1:0]            port_wr_req;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr;
  logic [NUM_PORTS*SIZE_WIDTH-1:0] port_size;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wr_data;
  logic [NUM_PORTS-1:0]            port_ready;
  logic [NUM_PORTS-1:0]            port_rd_valid;
  logic [DATA_WIDTH-1:0]           port_rd_data;

  logic                            ddr3_avl_ready;
  logic                            ddr3_avl_burstbegin;
  logic [SIZE_WIDTH-1:0]           ddr3_avl_size;
  logic                            ddr3_avl_read_req;
  logic                            ddr3_avl_write_req;
  logic [ADDR_WIDTH-1:0]           ddr3_avl_addr;
  logic [DATA_WIDTH-1:0]           ddr3_avl_wr_data;
  logic                            ddr3_avl_read_data_valid;
  logic [DATA_WIDTH-1:0]           ddr3_avl_read_data;

  modport slave (
    input  port_rd_req, port_wr_req, port_addr, port_size, port_wr_data,
    input  ddr3_avl_ready, ddr3_avl_read_data_valid, ddr3_avl_read_data,
    output port_ready, port_rd_valid, port_rd_data,
    output ddr3_avl_burstbegin, ddr3_avl_size, ddr3_avl_read_req,
    output ddr3_avl_write_req, ddr3_avl_addr, ddr3_avl_wr_data
  );

  modport master (
    output port_rd_req, port_wr_req, port_addr, port_size, port_wr_data,
    output ddr3_avl_ready, ddr3_avl_read_data_valid, ddr3_avl_read_data,
    input  port_ready, port_rd_valid, port_rd_data,
    input  ddr3_avl_burstbegin, ddr3_avl_size, ddr3_avl_read_req,
    input  ddr3_avl_write_req, ddr3_avl_addr, ddr3_avl_wr_data
  );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_port_arbiter
// Round-robin arbiter placing NUM_PORTS read/write clients onto the single
// DDR3 controller Avalon-MM port. A write grant is held for the whole burst.
// Read returns are steered back to the issuing port via an in-order tag FIFO
// holding {port, burst size} per outstanding read command.
// Ports:
//   ddr3_clk      controller clock (only clock)
//   reset         asynchronous active-high reset
//   bus           client + controller signals (ddr3_port_arbiter_if.slave)
//   rd_return_err sticky flag: a read beat came back with no outstanding tag
// ---------------------------------------------------------------------------
module ddr3_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 128,
  parameter int SIZE_WIDTH = 3,
  parameter int TAG_DEPTH  = 16
) (
  input  logic              ddr3_clk,
  input  logic              reset,
  ddr3_port_arbiter_if.slave bus,
  output logic              rd_return_err
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST} state_t;

  state_t                state_reg, state_next;
  logic [PW-1:0]         grant_reg, grant_next;
  logic [PW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [SIZE_WIDTH-1:0] size_reg, size_next;
  logic [SIZE_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;

  // Tag FIFO: small, read asynchronously so returns route with zero latency.
  logic [PW-1:0]         tag_port_mem [TAG_DEPTH];
  logic [SIZE_WIDTH-1:0] tag_size_mem [TAG_DEPTH];
  logic [TW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [TW:0]           count_reg;
  logic [SIZE_WIDTH-1:0] ret_beat_reg;
  logic                  rd_err_reg;

  logic                  tag_empty, tag_push, tag_pop, ret_accept, read_block;
  logic [PW-1:0]         head_port;
  logic [SIZE_WIDTH-1:0] head_size;
  logic [NUM_PORTS-1:0]  eligible, ready_vec, rd_valid_vec;
  logic                  win_found;
  logic [PW-1:0]         win_port;
  logic [SIZE_WIDTH-1:0] win_size;

  logic                  avl_burstbegin, avl_read_req, avl_write_req;
  logic [SIZE_WIDTH-1:0] avl_size;
  logic [ADDR_WIDTH-1:0] avl_addr;
  logic [DATA_WIDTH-1:0] avl_wr_data;

  assign tag_empty  = (count_reg == '0);
  assign head_port  = tag_port_mem[rd_ptr_reg];
  assign head_size  = tag_size_mem[rd_ptr_reg];
  assign ret_accept = bus.ddr3_avl_read_data_valid && !tag_empty;
  assign tag_pop    = ret_accept && ((ret_beat_reg + SIZE_WIDTH'(1)) == head_size);
  // A tag completing this cycle frees a slot for the grant being decided now.
  assign read_block = (count_reg == (TW+1)'(TAG_DEPTH)) && !tag_pop;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign eligible[gi]     = (bus.port_rd_req[gi] && !read_block) || bus.port_wr_req[gi];
    assign rd_valid_vec[gi] = ret_accept && (head_port == PW'(gi));
  end

  // First eligible port searching upward from rr_ptr+1; scanning k downward
  // lets the nearest port overwrite farther ones.
  always_comb begin
    win_found = 1'b0;
    win_port  = rr_ptr_reg;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (eligible[PW'((int'(rr_ptr_reg) + k) % NUM_PORTS)]) begin
        win_found = 1'b1;
        win_port  = PW'((int'(rr_ptr_reg) + k) % NUM_PORTS);
      end
    end
  end

  assign win_size = (bus.port_size[win_port*SIZE_WIDTH +: SIZE_WIDTH] == '0) ?
                    SIZE_WIDTH'(1) : bus.port_size[win_port*SIZE_WIDTH +: SIZE_WIDTH];

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    size_next      = size_reg;
    beat_cnt_next  = beat_cnt_reg;
    tag_push       = 1'b0;
    ready_vec      = '0;
    avl_burstbegin = 1'b0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_size       = '0;
    avl_addr       = '0;
    avl_wr_data    = '0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next    = win_port;
          rr_ptr_next   = win_port;
          size_next     = win_size;
          beat_cnt_next = win_size;
          // Read wins over a simultaneous write unless the tag FIFO is full.
          state_next    = (bus.port_rd_req[win_port] && !read_block) ? RD_CMD : WR_BURST;
        end
      end
      RD_CMD: begin
        avl_read_req   = 1'b1;
        avl_burstbegin = 1'b1;
        avl_size       = size_reg;
        avl_addr       = bus.port_addr[grant_reg*ADDR_WIDTH +: ADDR_WIDTH];
        if (bus.ddr3_avl_ready) begin
          ready_vec[grant_reg] = 1'b1;
          tag_push             = 1'b1;
          state_next           = IDLE;
        end
      end
      WR_BURST: begin
        avl_write_req  = bus.port_wr_req[grant_reg];
        avl_burstbegin = (beat_cnt_reg == size_reg);
        avl_size       = size_reg;
        avl_addr       = bus.port_addr[grant_reg*ADDR_WIDTH +: ADDR_WIDTH];
        avl_wr_data    = bus.port_wr_data[grant_reg*DATA_WIDTH +: DATA_WIDTH];
        if (avl_write_req && bus.ddr3_avl_ready) begin
          ready_vec[grant_reg] = 1'b1;
          beat_cnt_next        = beat_cnt_reg - SIZE_WIDTH'(1);
          if (beat_cnt_reg == SIZE_WIDTH'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= PW'(NUM_PORTS - 1);
      size_reg     <= '0;
      beat_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ret_beat_reg <= '0;
      rd_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      size_reg     <= size_next;
      beat_cnt_reg <= beat_cnt_next;
      if (tag_push) wr_ptr_reg <= wr_ptr_reg + TW'(1);
      if (tag_pop)  rd_ptr_reg <= rd_ptr_reg + TW'(1);
      case ({tag_push, tag_pop})
        2'b10:   count_reg <= count_reg + (TW+1)'(1);
        2'b01:   count_reg <= count_reg - (TW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (ret_accept) ret_beat_reg <= tag_pop ? '0 : ret_beat_reg + SIZE_WIDTH'(1);
      if (bus.ddr3_avl_read_data_valid && tag_empty) rd_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge ddr3_clk) begin
    if (tag_push) begin
      tag_port_mem[wr_ptr_reg] <= grant_reg;
      tag_size_mem[wr_ptr_reg] <= size_reg;
    end
  end

  assign bus.port_ready          = ready_vec;
  assign bus.port_rd_valid       = rd_valid_vec;
  assign bus.port_rd_data        = bus.ddr3_avl_read_data;
  assign bus.ddr3_avl_burstbegin = avl_burstbegin;
  assign bus.ddr3_avl_size       = avl_size;
  assign bus.ddr3_avl_read_req   = avl_read_req;
  assign bus.ddr3_avl_write_req  = avl_write_req;
  assign bus.ddr3_avl_addr       = avl_addr;
  assign bus.ddr3_avl_wr_data    = avl_wr_data;
  assign rd_return_err           = rd_err_reg;
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
module tb_ddr3_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int SW = 3;
  localparam int TD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_return_err;

  always #5 clk = ~clk;

  ddr3_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) bus ();

  ddr3_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .SIZE_WIDTH(SW), .TAG_DEPTH(TD)) dut (
    .ddr3_clk(clk), .reset(rst), .bus(bus), .rd_return_err(rd_return_err));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: last granted port, outstanding read tags, beat count.
  int          rr_last = NP - 1;
  int          tag_port_q[$];
  int          tag_size_q[$];
  int          ret_beat = 0;
  logic [AW-1:0] p_addr [NP];
  int          p_size [NP];

  function automatic int eff_size(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int pick(input logic [NP-1:0] req);
    for (int k = 1; k <= NP; k++) begin
      int idx;
      idx = (rr_last + k) % NP;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_port(input int p, input logic [AW-1:0] a, input int s);
    p_addr[p] = a;
    p_size[p] = s;
    bus.port_addr[p*AW +: AW] = a;
    bus.port_size[p*SW +: SW] = SW'(s);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.port_rd_req = '0; bus.port_wr_req = '0; bus.port_addr = '0;
    bus.port_size = '0; bus.port_wr_data = '0; bus.ddr3_avl_ready = 1'b1;
    bus.ddr3_avl_read_data_valid = 1'b0; bus.ddr3_avl_read_data = '0;
    @(negedge clk);
    n_checks++;
    if ({bus.ddr3_avl_read_req, bus.ddr3_avl_write_req, bus.ddr3_avl_burstbegin,
         bus.port_ready, bus.port_rd_valid} !== '0)
      $display("FAIL reset_ctrl got rd=%b wr=%b bb=%b rdy=%b v=%b want all 0",
               bus.ddr3_avl_read_req, bus.ddr3_avl_write_req, bus.ddr3_avl_burstbegin,
               bus.port_ready, bus.port_rd_valid);
    else n_pass++;
    n_checks++;
    if ({bus.ddr3_avl_addr, bus.ddr3_avl_size} !== '0 || bus.ddr3_avl_wr_data !== '0)
      $display("FAIL reset_bus got addr=%h size=%0d want 0", bus.ddr3_avl_addr, bus.ddr3_avl_size);
    else n_pass++;
    n_checks++;
    if (rd_return_err !== 1'b0) $display("FAIL reset_err got %b want 0", rd_return_err);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    tag_port_q.delete(); tag_size_q.delete(); ret_beat = 0; rr_last = NP - 1;
    $display("reset applied");
  endtask

  // Single requester read; checks 1-cycle command latency and the command fields.
  task automatic issue_read(input int p, input logic [AW-1:0] a, input int s, input bit rnd);
    bit accepted = 0;
    logic [NP-1:0] exp_rdy;
    set_port(p, a, s);
    bus.port_rd_req[p] = 1'b1;
    bus.ddr3_avl_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ddr3_avl_read_req !== 1'b0) $display("FAIL rd_idle_cycle got read_req=%b want 0", bus.ddr3_avl_read_req);
    else n_pass++;
    for (int c = 0; c < 40 && !accepted; c++) begin
      @(posedge clk); #1;
      bus.ddr3_avl_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (bus.ddr3_avl_read_req !== 1'b1) $display("FAIL rd_latency got read_req=%b want 1", bus.ddr3_avl_read_req);
        else n_pass++;
      end
      if (bus.ddr3_avl_read_req === 1'b1) begin
        exp_rdy = '0;
        if (bus.ddr3_avl_ready) exp_rdy[p] = 1'b1;
        n_checks++;
        if (bus.ddr3_avl_addr !== a || bus.ddr3_avl_size !== SW'(eff_size(s)) || bus.ddr3_avl_burstbegin !== 1'b1)
          $display("FAIL rd_cmd port %0d got addr=%h size=%0d bb=%b want addr=%h size=%0d bb=1",
                   p, bus.ddr3_avl_addr, bus.ddr3_avl_size, bus.ddr3_avl_burstbegin, a, eff_size(s));
        else n_pass++;
        n_checks++;
        if (bus.port_ready !== exp_rdy) $display("FAIL rd_ready got %b want %b", bus.port_ready, exp_rdy);
        else n_pass++;
        if (bus.ddr3_avl_ready) begin
          accepted = 1;
          tag_port_q.push_back(p); tag_size_q.push_back(eff_size(s)); rr_last = p;
          $display("read cmd port %0d addr %h size %0d", p, a, eff_size(s));
        end
      end
    end
    if (!accepted) begin
      n_checks++;
      $display("FAIL rd_timeout port %0d got no accept want accept", p);
    end
    @(posedge clk); #1;
    bus.port_rd_req[p] = 1'b0;
    bus.ddr3_avl_ready = 1'b1;
  endtask

  // Several ports request reads at once; grant order checked against model.
  task automatic run_concurrent(input logic [NP-1:0] mask, input bit rnd);
    logic [NP-1:0] pending = mask;
    logic [NP-1:0] exp_rdy;
    int drop, e;
    for (int p = 0; p < NP; p++)
      if (mask[p]) begin
        set_port(p, AW'($urandom()), $urandom_range(0, 7));
        bus.port_rd_req[p] = 1'b1;
      end
    for (int c = 0; c < 200 && pending != '0; c++) begin
      drop = -1;
      @(negedge clk);
      if (bus.ddr3_avl_read_req === 1'b1 && bus.ddr3_avl_ready) begin
        e = pick(pending);
        exp_rdy = '0; exp_rdy[e] = 1'b1;
        n_checks++;
        if (bus.port_ready !== exp_rdy || bus.ddr3_avl_addr !== p_addr[e])
          $display("FAIL rr_order got ready=%b addr=%h want ready=%b addr=%h",
                   bus.port_ready, bus.ddr3_avl_addr, exp_rdy, p_addr[e]);
        else n_pass++;
        tag_port_q.push_back(e); tag_size_q.push_back(eff_size(p_size[e]));
        rr_last = e; pending[e] = 1'b0; drop = e;
        $display("rr read cmd port %0d addr %h size %0d", e, p_addr[e], eff_size(p_size[e]));
      end else begin
        n_checks++;
        if (bus.port_ready !== '0) $display("FAIL rr_no_accept got ready=%b want 0", bus.port_ready);
        else n_pass++;
      end
      @(posedge clk); #1;
      if (drop >= 0) bus.port_rd_req[drop] = 1'b0;
      bus.ddr3_avl_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (pending != '0) begin
      n_checks++;
      $display("FAIL rr_timeout got pending=%b want 0", pending);
      bus.port_rd_req = '0;
    end
    bus.ddr3_avl_ready = 1'b1;
  endtask

  // Write burst from port p; optional read requester ip raised after beat 1.
  task automatic run_write(input int p, input logic [AW-1:0] a, input int s, input int ip, input bit rnd);
    logic [DW-1:0] bd [8];
    logic [NP-1:0] exp_rdy;
    int eff = eff_size(s);
    int beat = 0;
    bit wr_en = 1, done = 0, stalled = 0;
    for (int i = 0; i < 8; i++) bd[i] = rand_data();
    set_port(p, a, s);
    bus.port_wr_req[p] = 1'b1;
    bus.port_wr_data[p*DW +: DW] = bd[0];
    bus.ddr3_avl_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.ddr3_avl_write_req !== 1'b0) $display("FAIL wr_idle_cycle got write_req=%b want 0", bus.ddr3_avl_write_req);
    else n_pass++;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      if (rnd && c > 0) begin
        wr_en = ($urandom_range(0, 3) != 0);
        bus.ddr3_avl_ready = ($urandom_range(0, 3) != 0);
      end else if (!rnd) begin
        bus.ddr3_avl_ready = !(beat == 1 && !stalled);
        if (beat == 1) stalled = 1;
      end
      bus.port_wr_req[p] = wr_en;
      bus.port_wr_data[p*DW +: DW] = bd[beat];
      if (ip >= 0 && beat == 1) bus.port_rd_req[ip] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.ddr3_avl_write_req !== wr_en || bus.ddr3_avl_read_req !== 1'b0)
        $display("FAIL wr_req got wr=%b rd=%b want wr=%b rd=0", bus.ddr3_avl_write_req, bus.ddr3_avl_read_req, wr_en);
      else n_pass++;
      n_checks++;
      if (bus.ddr3_avl_burstbegin !== (beat == 0))
        $display("FAIL wr_burstbegin beat %0d got %b want %b", beat, bus.ddr3_avl_burstbegin, beat == 0);
      else n_pass++;
      if (wr_en) begin
        n_checks++;
        if (bus.ddr3_avl_wr_data !== bd[beat] || bus.ddr3_avl_addr !== a || bus.ddr3_avl_size !== SW'(eff))
          $display("FAIL wr_beat %0d got data=%h addr=%h want data=%h addr=%h", beat,
                   bus.ddr3_avl_wr_data, bus.ddr3_avl_addr, bd[beat], a);
        else n_pass++;
      end
      exp_rdy = '0;
      if (wr_en && bus.ddr3_avl_ready) exp_rdy[p] = 1'b1;
      n_checks++;
      if (bus.port_ready !== exp_rdy) $display("FAIL wr_ready got %b want %b", bus.port_ready, exp_rdy);
      else n_pass++;
      if (wr_en && bus.ddr3_avl_ready) begin
        $display("write beat %0d/%0d port %0d addr %h", beat + 1, eff, p, a);
        beat++;
        if (beat == eff) done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL wr_timeout got beats=%0d want %0d", beat, eff);
    end
    @(posedge clk); #1;
    bus.port_wr_req[p] = 1'b0;
    bus.ddr3_avl_ready = 1'b1;
    rr_last = p;
    if (ip >= 0) begin
      @(negedge clk);
      n_checks++;
      if (bus.ddr3_avl_read_req !== 1'b0) $display("FAIL rd_after_burst_idle got %b want 0", bus.ddr3_avl_read_req);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      exp_rdy = '0; exp_rdy[ip] = 1'b1;
      n_checks++;
      if (bus.ddr3_avl_read_req !== 1'b1 || bus.port_ready !== exp_rdy || bus.ddr3_avl_addr !== p_addr[ip])
        $display("FAIL rd_after_burst got rd=%b ready=%b want rd=1 ready=%b", bus.ddr3_avl_read_req, bus.port_ready, exp_rdy);
      else n_pass++;
      tag_port_q.push_back(ip); tag_size_q.push_back(eff_size(p_size[ip])); rr_last = ip;
      $display("read cmd port %0d after burst", ip);
      @(posedge clk); #1;
      bus.port_rd_req[ip] = 1'b0;
    end
  endtask

  // One read-return beat, checked against the head of the model tag queue.
  task automatic return_beat();
    logic [DW-1:0] d = rand_data();
    logic [NP-1:0] exp_v = '0;
    if (tag_port_q.size() > 0) exp_v[tag_port_q[0]] = 1'b1;
    bus.ddr3_avl_read_data_valid = 1'b1;
    bus.ddr3_avl_read_data = d;
    @(negedge clk);
    n_checks++;
    if (bus.port_rd_valid !== exp_v || bus.port_rd_data !== d)
      $display("FAIL ret_beat got valid=%b data=%h want valid=%b data=%h", bus.port_rd_valid, bus.port_rd_data, exp_v, d);
    else n_pass++;
    $display("return beat valid=%b", exp_v);
    if (tag_port_q.size() > 0) begin
      ret_beat++;
      if (ret_beat == tag_size_q[0]) begin
        void'(tag_port_q.pop_front()); void'(tag_size_q.pop_front()); ret_beat = 0;
      end
    end
    @(posedge clk); #1;
    bus.ddr3_avl_read_data_valid = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 200 && tag_port_q.size() > 0; g++) return_beat();
  endtask

  task automatic test_single_read();
    test_reset();
    issue_read(0, 26'h100, 2, 0);
    drain();
  endtask

  task automatic test_round_robin();
    test_reset();
    run_concurrent(4'b0111, 0);
    drain();
    run_concurrent(4'b1001, 0);
    drain();
  endtask

  task automatic test_write_burst();
    test_reset();
    set_port(1, AW'($urandom()), 2);
    run_write(2, AW'($urandom()), 4, 1, 0);
    drain();
  endtask

  task automatic test_tag_full();
    logic [NP-1:0] exp_rdy;
    int hs;
    test_reset();
    for (int i = 0; i < TD; i++) issue_read($urandom_range(0, NP - 1), AW'($urandom()), $urandom_range(0, 7), 0);
    set_port(0, AW'($urandom()), 1);
    bus.port_rd_req[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.ddr3_avl_read_req !== 1'b0 || bus.port_ready !== '0)
        $display("FAIL full_block got rd=%b ready=%b want 0", bus.ddr3_avl_read_req, bus.port_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    run_write(1, AW'($urandom()), $urandom_range(0, 7), -1, 1);
    hs = tag_size_q[0];
    for (int b = 0; b < hs; b++) begin
      return_beat();
      @(negedge clk);
      exp_rdy = '0;
      if (b == hs - 1) exp_rdy[0] = 1'b1;
      n_checks++;
      if (bus.ddr3_avl_read_req !== (b == hs - 1) || bus.port_ready !== exp_rdy)
        $display("FAIL full_resume beat %0d got rd=%b ready=%b want rd=%b ready=%b",
                 b, bus.ddr3_avl_read_req, bus.port_ready, b == hs - 1, exp_rdy);
      else n_pass++;
      if (b == hs - 1) begin
        tag_port_q.push_back(0); tag_size_q.push_back(1); rr_last = 0;
        $display("read cmd port 0 after tag freed");
      end
      @(posedge clk); #1;
      if (b == hs - 1) bus.port_rd_req[0] = 1'b0;
    end
    drain();
  endtask

  task automatic test_interleave();
    test_reset();
    issue_read(1, AW'($urandom()), 3, 0);
    issue_read(3, AW'($urandom()), 1, 0);
    drain();
  endtask

  task automatic test_random();
    test_reset();
    for (int r = 0; r < 6; r++) begin
      run_concurrent(4'($urandom_range(1, 15)), 1);
      run_write($urandom_range(0, NP - 1), AW'($urandom()), $urandom_range(0, 7), -1, 1);
      drain();
    end
  endtask

  task automatic test_return_err();
    test_reset();
    return_beat();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rd_return_err !== 1'b1) $display("FAIL err_sticky got %b want 1", rd_return_err);
      else n_pass++;
      @(posedge clk); #1;
    end
    test_reset();
    issue_read(2, AW'($urandom()), 2, 0);
    test_reset();
    return_beat();
    @(negedge clk);
    n_checks++;
    if (rd_return_err !== 1'b1) $display("FAIL err_after_reset_flush got %b want 1", rd_return_err);
    else n_pass++;
    test_reset();
  endtask

  initial begin
    bus.port_rd_req = '0; bus.port_wr_req = '0; bus.port_addr = '0;
    bus.port_size = '0; bus.port_wr_data = '0; bus.ddr3_avl_ready = 1'b1;
    bus.ddr3_avl_read_data_valid = 1'b0; bus.ddr3_avl_read_data = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_burst();
    test_tag_full();
    test_interleave();
    test_random();
    test_return_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
